// File: rtl/event_player.sv
// event_player: replays timestamped samples onto output pins against a
// prescaled time base. Records arrive on a valid/ready stream; each record is
// held until the time base reaches its timestamp, then its data word is driven.
module event_player #(
  parameter int TIME_LENGTH = 24,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            i_prescaler,
  input  logic                   i_run,
  input  logic                   i_rec_valid,
  output logic                   o_rec_ready,
  input  logic [TIME_LENGTH-1:0] i_rec_time,
  input  logic [DATA_WIDTH-1:0]  i_rec_data,
  input  logic                   i_rec_last,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [TIME_LENGTH-1:0] o_time,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_late
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  typedef struct packed {
    logic [TIME_LENGTH-1:0] tstamp;
    logic [DATA_WIDTH-1:0]  data;
    logic                   last;
  } rec_t;

  state_t      state, state_nx;
  rec_t        hold;
  logic [31:0] pcnt;
  logic        accept, apply, due, tb_run, start;

  // Time base only advances while a pattern is actively being played.
  assign tb_run = (state == FETCH) || (state == WAIT);
  // Unsigned compare against the registered time: a tick on the apply edge
  // is not seen until the following cycle.
  assign due    = (o_time >= hold.tstamp);
  assign start  = (state == IDLE) && i_run;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; dropping i_run aborts from any active state.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    apply    = 1'b0;
    case (state)
      IDLE:  if (i_run) state_nx = FETCH;
      FETCH: begin
        if (!i_run) state_nx = IDLE;
        else if (i_rec_valid && o_rec_ready) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!i_run) state_nx = IDLE;
        else if (due) begin
          apply    = 1'b1;
          state_nx = hold.last ? DONE : FETCH;
        end
      end
      DONE:    if (!i_run) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Prescaler and time base: cleared whenever run is low, frozen in DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pcnt   <= '0;
      o_time <= '0;
    end else if (!i_run) begin
      pcnt   <= '0;
      o_time <= '0;
    end else if (tb_run) begin
      if (pcnt >= i_prescaler) begin
        pcnt   <= '0;
        o_time <= o_time + TIME_LENGTH'(1);
      end else begin
        pcnt   <= pcnt + 32'd1;
      end
    end
  end

  // Hold register: captured on accept, dropped when the player goes idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold <= '0;
    end else if (accept) begin
      hold.tstamp <= i_rec_time;
      hold.data   <= i_rec_data;
      hold.last   <= i_rec_last;
    end else if (state_nx == IDLE) begin
      hold <= '0;
    end
  end

  // Output pins and sticky lateness; o_data survives abort on purpose so the
  // pins do not glitch when playback is stopped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
      o_late <= 1'b0;
    end else begin
      if (start) o_late <= 1'b0;
      if (apply) begin
        o_data <= hold.data;
        if (o_time != hold.tstamp) o_late <= 1'b1;
      end
    end
  end

  // Registered state decodes for handshake and status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rec_ready <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_rec_ready <= (state_nx == FETCH);
      o_busy      <= (state_nx == FETCH) || (state_nx == WAIT);
      o_done      <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_event_player.sv
// Directed bench for event_player: a default-width instance for the main
// scenarios and a 4-bit time base instance for wraparound.
module tb_event_player;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_prescaler;
  logic        i_run, i_rec_valid, o_rec_ready, i_rec_last;
  logic [23:0] i_rec_time, o_time;
  logic [7:0]  i_rec_data, o_data;
  logic        o_busy, o_done, o_late;

  logic [31:0] w_prescaler;
  logic        w_run, w_rec_valid, w_rec_ready, w_rec_last;
  logic [3:0]  w_rec_time, w_time;
  logic [7:0]  w_rec_data, w_data;
  logic        w_busy, w_done, w_late;

  always #5 i_clk = ~i_clk;

  event_player dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_prescaler(i_prescaler), .i_run(i_run),
    .i_rec_valid(i_rec_valid), .o_rec_ready(o_rec_ready), .i_rec_time(i_rec_time),
    .i_rec_data(i_rec_data), .i_rec_last(i_rec_last), .o_data(o_data),
    .o_time(o_time), .o_busy(o_busy), .o_done(o_done), .o_late(o_late)
  );

  event_player #(.TIME_LENGTH(4), .DATA_WIDTH(8)) dut_w (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_prescaler(w_prescaler), .i_run(w_run),
    .i_rec_valid(w_rec_valid), .o_rec_ready(w_rec_ready), .i_rec_time(w_rec_time),
    .i_rec_data(w_rec_data), .i_rec_last(w_rec_last), .o_data(w_data),
    .o_time(w_time), .o_busy(w_busy), .o_done(w_done), .o_late(w_late)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] r_time [4];
  logic [7:0]  r_data [4];
  logic        r_last [4];
  logic [23:0] app_pt [4];
  logic        app_late [4];
  int          acc_cyc [4];
  int          app_cyc [4];
  int          n_app;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rec(input int k);
    i_rec_time = r_time[k];
    i_rec_data = r_data[k];
    i_rec_last = r_last[k];
  endtask

  // Start from IDLE and stream n records; log accept/apply cycles counted
  // from the run-start edge (cycle 1), plus o_time just before each apply.
  task automatic play(input int n, input int budget);
    int idx = 0;
    int cyc = 0;
    logic [7:0]  pd;
    logic [23:0] pt;
    logic        fire;
    n_app = 0;
    set_rec(0);
    i_rec_valid = 1'b1;
    i_run = 1'b1;
    pd = o_data;
    while (n_app < n && cyc < budget) begin
      fire = i_rec_valid && o_rec_ready;
      pt = o_time;
      step();
      cyc++;
      if (fire) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < n) set_rec(idx);
        else i_rec_valid = 1'b0;
      end
      if (o_data !== pd) begin
        app_pt[n_app] = pt;
        app_late[n_app] = o_late;
        app_cyc[n_app] = cyc;
        n_app++;
        pd = o_data;
      end
    end
    chk("play_applied", n_app, n);
  endtask

  initial begin
    logic [7:0] wpd;
    logic [3:0] wpt;
    logic       found;
    int         wcnt;
    i_rst_n = 1'b0; i_prescaler = '0; i_run = 1'b0; i_rec_valid = 1'b0;
    i_rec_time = '0; i_rec_data = '0; i_rec_last = 1'b0;
    w_prescaler = '0; w_run = 1'b0; w_rec_valid = 1'b0;
    w_rec_time = '0; w_rec_data = '0; w_rec_last = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_time", o_time, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ready", o_rec_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_late", o_late, 0);

    // Prescaler 3: ticks every 4 clocks, all records on time
    i_prescaler = 3;
    r_time[0] = 2; r_data[0] = 8'h11; r_last[0] = 1'b0;
    r_time[1] = 5; r_data[1] = 8'h22; r_last[1] = 1'b0;
    r_time[2] = 9; r_data[2] = 8'h33; r_last[2] = 1'b1;
    play(3, 200);
    chk("p3_t0", app_pt[0], 2);
    chk("p3_t1", app_pt[1], 5);
    chk("p3_t2", app_pt[2], 9);
    chk("p3_data", o_data, 8'h33);
    chk("p3_done", o_done, 1);
    chk("p3_busy", o_busy, 0);
    repeat (10) step();
    chk("p3_frozen", o_time, 9);
    chk("p3_late", o_late, 0);
    i_run = 1'b0;
    step();
    chk("p3_abort_done", o_done, 0);
    chk("p3_abort_time", o_time, 0);

    // Prescaler 0, timestamp 0 valid at start: accepted E0+1, applied E0+2 late
    i_prescaler = 0;
    r_time[0] = 0; r_data[0] = 8'h7E; r_last[0] = 1'b1;
    play(1, 20);
    chk("p0_acc", acc_cyc[0], 2);
    chk("p0_app", app_cyc[0], 3);
    chk("p0_pt", app_pt[0], 1);
    chk("p0_late", app_late[0], 1);
    chk("p0_data", o_data, 8'h7E);
    i_run = 1'b0;
    step();

    // Prescaler 9, past timestamp after a future one
    i_prescaler = 9;
    r_time[0] = 10; r_data[0] = 8'h01; r_last[0] = 1'b0;
    r_time[1] = 4;  r_data[1] = 8'h02; r_last[1] = 1'b1;
    play(2, 300);
    chk("nm_late0", app_late[0], 0);
    chk("nm_pt0", app_pt[0], 10);
    chk("nm_gap", app_cyc[1] - acc_cyc[1], 1);
    chk("nm_late1", app_late[1], 1);
    chk("nm_data", o_data, 8'h02);

    // Abort from DONE keeps o_late; restart clears it
    i_run = 1'b0;
    step();
    chk("ab_late_held", o_late, 1);
    chk("ab_done_clr", o_done, 0);
    i_rec_time = 50; i_rec_data = 8'h44; i_rec_last = 1'b0; i_rec_valid = 1'b1;
    i_run = 1'b1;
    step();
    chk("ab_late_clr", o_late, 0);
    chk("ab_ready", o_rec_ready, 1);
    repeat (20) step();
    chk("ab_wait_busy", o_busy, 1);
    chk("ab_wait_ready", o_rec_ready, 0);
    i_run = 1'b0; i_rec_valid = 1'b0;
    step();
    chk("ab_idle_ready", o_rec_ready, 0);
    chk("ab_idle_time", o_time, 0);
    chk("ab_idle_busy", o_busy, 0);
    chk("ab_data_kept", o_data, 8'h02);
    i_run = 1'b1;
    step();
    chk("ab_restart_time", o_time, 0);
    repeat (10) step();
    chk("ab_first_tick", o_time, 1);
    chk("ab_no_apply", o_data, 8'h02);
    i_run = 1'b0;
    step();

    // Async reset while a record waits and o_data = 0xA5
    i_prescaler = 0;
    r_time[0] = 0; r_data[0] = 8'hA5; r_last[0] = 1'b0;
    play(1, 20);
    i_rec_time = 100; i_rec_data = 8'h5A; i_rec_last = 1'b1; i_rec_valid = 1'b1;
    step();
    i_rec_valid = 1'b0;
    step();
    chk("rw_data", o_data, 8'hA5);
    chk("rw_busy", o_busy, 1);
    chk("rw_late", o_late, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("ra_data", o_data, 0);
    chk("ra_time", o_time, 0);
    chk("ra_busy", o_busy, 0);
    chk("ra_late", o_late, 0);
    chk("ra_ready", o_rec_ready, 0);
    chk("ra_done", o_done, 0);
    i_run = 1'b0;
    #2 i_rst_n = 1'b1;
    step();
    chk("rr_time", o_time, 0);
    chk("rr_ready", o_rec_ready, 0);
    chk("rr_busy", o_busy, 0);

    // 4-bit time base wraps; record for t=3 waits for the next lap
    w_prescaler = 0;
    w_run = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (w_time == 4'd15) found = 1'b1;
    end
    chk("wr_reach15", found, 1);
    step();
    chk("wr_to0", w_time, 0);
    w_rec_time = 3; w_rec_data = 8'h55; w_rec_last = 1'b1; w_rec_valid = 1'b1;
    wpd = w_data;
    wpt = '0;
    found = 1'b0;
    wcnt = 0;
    while (!found && wcnt < 40) begin
      if (w_rec_valid && w_rec_ready) begin
        step();
        w_rec_valid = 1'b0;
      end else begin
        wpt = w_time;
        step();
      end
      wcnt++;
      if (w_data !== wpd) found = 1'b1;
    end
    chk("wr_applied", found, 1);
    chk("wr_pt", wpt, 3);
    chk("wr_data", w_data, 8'h55);
    chk("wr_late", w_late, 0);
    chk("wr_done", w_done, 1);
    w_run = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
